vs_spi_target: RTL and testbench

- Synthesizable model of the VS1003B serial side: SCI command target plus SDI data sink with DREQ flow control.
- Sits opposite the MP3 controller in loop-back/self-test builds and in the verification bench.
- Decodes 32-bit SCI frames into a 16x16 register file and collects SDI bytes into a FIFO.
- Exposes the FIFO and key registers to a downstream consumer.

---
 rtl/vs_pkg.sv | 19 +
 rtl/vs_sdi_fifo.sv | 53 +++++
 rtl/vs_spi_target.sv | 204 ++++++++++++++++++++
 tb/tb_vs_spi_target.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vs_pkg.sv
// Shared VS1003B serial-side constants and state encoding.
// The MP3 controller imports this package too, so keep values stable.
package vs_pkg;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [3:0] REG_MODE = 4'h0;
    localparam logic [3:0] REG_VOL  = 4'hB;
    localparam int SM_RESET_BIT = 2;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_IDLE,
        ST_SCI_CMD,
        ST_SCI_WR,
        ST_SCI_RD,
        ST_SDI,
        ST_ERR
    } vs_state_t;
endpackage

// File: rtl/vs_sdi_fifo.sv
// Synchronous byte FIFO for SDI data; wrap-around pointers one bit wider than the address.
module vs_sdi_fifo
    import vs_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     clr,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] used;
    logic [7:0]  mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign used    = wr_ptr - rd_ptr;
    assign empty   = (used == '0);
    assign full    = (used == DEPTH_W);
    assign free    = DEPTH_W - used;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ONE;
            if (do_pop)  rd_ptr <= rd_ptr + ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/vs_spi_target.sv
// VS1003B serial-side target: SCI register access and SDI byte sink with DREQ flow control.
//   state   | meaning
//   BOOT    | post-reset delay, DREQ held low
//   IDLE    | waiting for XCS or XDCS
//   SCI_CMD | shifting opcode and address
//   SCI_WR  | shifting write data
//   SCI_RD  | driving register contents on SO
//   SDI     | collecting data bytes into the FIFO
//   ERR     | protocol error, wait for both selects high
module vs_spi_target
    import vs_pkg::*;
#(
    parameter int FIFO_DEPTH  = 64,
    parameter int DREQ_MARGIN = 32,
    parameter int BOOT_CYCLES = 1000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        XRESET,
    input  logic        XCS,
    input  logic        XDCS,
    input  logic        SCLK,
    input  logic        SI,
    output logic        SO,
    output logic        DREQ,
    output logic [15:0] mode,
    output logic [15:0] vol,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        ovf,
    output logic        frm_err
);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(BOOT_CYCLES + 1);
    localparam logic [BW-1:0] BOOT_LOAD = BW'(BOOT_CYCLES);
    localparam logic [FW:0]   MARGIN_W  = (FW+1)'(DREQ_MARGIN);
    localparam logic [4:0]    SYNC_RST  = 5'b11100;

    logic [4:0]  sync1, sync2;
    logic        xreset_s, xcs_s, xdcs_s, sclk_s, si_s;
    logic        sclk_q, xcs_q, xdcs_q;
    logic        sclk_rise, sclk_fall, xcs_rise, xdcs_rise;

    vs_state_t   state_q, state_d;
    logic [5:0]  bit_cnt;
    logic [15:0] sh_q, shift_word, so_sh;
    logic [3:0]  addr_q;
    logic [BW-1:0] boot_cnt;
    logic        so_q, dreq_q, ovf_q, err_q, wr_pend, soft_pend;
    logic        err_set, push_req, wr_fire, dreq_d, soft_wr, fifo_clr;
    logic [15:0] regs [16];

    logic        fifo_full, fifo_empty;
    logic [FW:0] fifo_free;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1  <= SYNC_RST;
            sync2  <= SYNC_RST;
            sclk_q <= 1'b0;
            xcs_q  <= 1'b1;
            xdcs_q <= 1'b1;
        end else begin
            sync1  <= {XRESET, XCS, XDCS, SCLK, SI};
            sync2  <= sync1;
            sclk_q <= sclk_s;
            xcs_q  <= xcs_s;
            xdcs_q <= xdcs_s;
        end
    end

    assign {xreset_s, xcs_s, xdcs_s, sclk_s, si_s} = sync2;
    assign sclk_rise  = sclk_s & ~sclk_q;
    assign sclk_fall  = ~sclk_s & sclk_q;
    assign xcs_rise   = xcs_s & ~xcs_q;
    assign xdcs_rise  = xdcs_s & ~xdcs_q;
    assign shift_word = {sh_q[14:0], si_s};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)           state_q <= ST_BOOT;
        else if (!xreset_s) state_q <= ST_BOOT;
        else                state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:    if (boot_cnt == '0) state_d = ST_IDLE;
            ST_IDLE: begin
                if (!xcs_s && xdcs_s)       state_d = ST_SCI_CMD;
                else if (xcs_s && !xdcs_s)  state_d = ST_SDI;
                else if (!xcs_s && !xdcs_s) state_d = ST_ERR;
            end
            ST_SCI_CMD: begin
                if (xcs_rise) state_d = ST_IDLE;
                else if (sclk_rise && bit_cnt == 6'd15) begin
                    if (shift_word[15:8] == OP_WRITE)     state_d = ST_SCI_WR;
                    else if (shift_word[15:8] == OP_READ) state_d = ST_SCI_RD;
                    else                                  state_d = ST_ERR;
                end
            end
            ST_SCI_WR, ST_SCI_RD: begin
                if (xcs_rise)
                    state_d = (bit_cnt == 6'd32 && soft_pend) ? ST_BOOT : ST_IDLE;
            end
            ST_SDI:     if (xdcs_rise) state_d = ST_IDLE;
            ST_ERR:     if (xcs_s && xdcs_s) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        err_set  = 1'b0;
        push_req = 1'b0;
        wr_fire  = (state_q == ST_SCI_WR) && sclk_rise && (bit_cnt == 6'd31);
        dreq_d   = (state_q != ST_BOOT) && (fifo_free >= MARGIN_W) &&
                   !(state_q inside {ST_SCI_CMD, ST_SCI_WR, ST_SCI_RD});
        case (state_q)
            ST_IDLE:    err_set = !xcs_s && !xdcs_s;
            ST_SCI_CMD: err_set = xcs_rise || (sclk_rise && bit_cnt == 6'd15 &&
                                  shift_word[15:8] != OP_WRITE && shift_word[15:8] != OP_READ);
            ST_SCI_WR, ST_SCI_RD: err_set = xcs_rise && (bit_cnt != 6'd32);
            ST_SDI:     push_req = sclk_rise && (bit_cnt[2:0] == 3'd7);
            default:    ;
        endcase
    end

    assign soft_wr  = wr_pend && (addr_q == REG_MODE) && sh_q[SM_RESET_BIT];
    assign fifo_clr = !xreset_s || soft_wr;

    // SDI reuses the frame bit counter modulo 8; SCI counting stops at 32 so the data word holds.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_cnt <= '0; sh_q <= '0; addr_q <= '0; so_sh <= '0; so_q <= 1'b0;
            dreq_q <= 1'b0; ovf_q <= 1'b0; err_q <= 1'b0; wr_pend <= 1'b0;
            soft_pend <= 1'b0; boot_cnt <= BOOT_LOAD;
        end else if (!xreset_s) begin
            bit_cnt <= '0; sh_q <= '0; addr_q <= '0; so_sh <= '0; so_q <= 1'b0;
            dreq_q <= 1'b0; wr_pend <= 1'b0; soft_pend <= 1'b0; boot_cnt <= BOOT_LOAD;
        end else begin
            dreq_q  <= dreq_d;
            wr_pend <= wr_fire;
            if (err_set) err_q <= 1'b1;
            if (push_req && fifo_full) ovf_q <= 1'b1;

            if (state_q == ST_IDLE) bit_cnt <= '0;
            else if (sclk_rise && (state_q == ST_SDI || bit_cnt != 6'd32)) begin
                bit_cnt <= bit_cnt + 6'd1;
                sh_q    <= shift_word;
            end

            if (state_q == ST_SCI_CMD && sclk_rise && bit_cnt == 6'd15) addr_q <= shift_word[3:0];

            if (state_q == ST_SCI_CMD && state_d == ST_SCI_RD)
                so_sh <= regs[shift_word[3:0]];
            else if (state_q == ST_SCI_RD && sclk_fall) begin
                so_q  <= so_sh[15];
                so_sh <= {so_sh[14:0], 1'b0};
            end else if (state_q != ST_SCI_RD)
                so_q <= 1'b0;

            if (soft_wr) soft_pend <= 1'b1;
            else if (state_q == ST_BOOT) soft_pend <= 1'b0;

            if (state_q != ST_BOOT && state_d == ST_BOOT) boot_cnt <= BOOT_LOAD;
            else if (state_q == ST_BOOT && boot_cnt != '0) boot_cnt <= boot_cnt - BW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (!xreset_s) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (wr_pend) begin
            if (addr_q == REG_MODE)
                regs[addr_q] <= sh_q & ~(16'd1 << SM_RESET_BIT);
            else
                regs[addr_q] <= sh_q;
        end
    end

    vs_sdi_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .clr       (fifo_clr),
        .push      (push_req),
        .push_data (shift_word[7:0]),
        .pop       (byte_ready),
        .head      (byte_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .free      (fifo_free)
    );

    assign SO         = so_q;
    assign DREQ       = dreq_q;
    assign mode       = regs[REG_MODE];
    assign vol        = regs[REG_VOL];
    assign byte_valid = !fifo_empty;
    assign ovf        = ovf_q;
    assign frm_err    = err_q;
endmodule

// File: tb/tb_vs_spi_target.sv
// Bench for vs_spi_target: SCI/SDI traffic against a register/queue model, FIFO output scoreboard.
module tb_vs_spi_target;
    localparam int DEPTH  = 64;
    localparam int MARGIN = 32;
    localparam int BOOT   = 1000;
    localparam int HALF   = 4;

    logic CLK = 1'b0, RST = 1'b0, XRESET = 1'b1, XCS = 1'b1, XDCS = 1'b1;
    logic SCLK = 1'b0, SI = 1'b0, byte_ready = 1'b0;
    logic        SO, DREQ, byte_valid, ovf, frm_err;
    logic [15:0] mode, vol;
    logic [7:0]  byte_data;

    int checks = 0;
    int failures = 0;
    logic [15:0] mregs [16];
    logic [7:0]  exp_q [$];
    logic [7:0]  mon_exp;
    logic        m_ovf;

    vs_spi_target #(.FIFO_DEPTH(DEPTH), .DREQ_MARGIN(MARGIN), .BOOT_CYCLES(BOOT)) dut (
        .CLK(CLK), .RST(RST), .XRESET(XRESET), .XCS(XCS), .XDCS(XDCS), .SCLK(SCLK), .SI(SI),
        .SO(SO), .DREQ(DREQ), .mode(mode), .vol(vol), .byte_data(byte_data),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .ovf(ovf), .frm_err(frm_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: each accepted FIFO byte must match the oldest expected byte.
    always @(negedge CLK) begin
        if (RST && byte_valid && byte_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL fifo_pop actual=%h required=no_byte", byte_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (byte_data !== mon_exp) begin
                    failures++;
                    $display("FAIL fifo_pop actual=%h required=%h", byte_data, mon_exp);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mregs[i] = '0;
        exp_q.delete();
    endtask

    task automatic model_write(input logic [3:0] a, input logic [15:0] d);
        if (a == 4'h0 && d[2]) begin
            mregs[0] = d & 16'hFFFB;
            exp_q.delete();
        end else mregs[a] = d;
    endtask

    task automatic spi_bit(input logic b, output logic so_b);
        SI = b;
        cyc(HALF);
        SCLK = 1'b1;
        cyc(HALF);
        so_b = SO;
        SCLK = 1'b0;
    endtask

    task automatic sci_frame(input logic [31:0] w, input int nbits,
                             output logic [15:0] rd, output logic dreq_mid);
        logic sob;
        rd = '0;
        dreq_mid = 1'b1;
        XCS = 1'b0;
        cyc(HALF);
        for (int i = 0; i < nbits; i++) begin
            spi_bit(w[31-i], sob);
            if (i >= 16) rd = {rd[14:0], sob};
            if (i == 8) dreq_mid = DREQ;
        end
        cyc(HALF);
        XCS = 1'b1;
        cyc(6);
    endtask

    task automatic sdi_byte(input logic [7:0] b);
        logic d;
        for (int i = 7; i >= 0; i--) spi_bit(b[i], d);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else m_ovf = 1'b1;
    endtask

    task automatic sdi_bits(input int n);
        logic d;
        for (int i = 0; i < n; i++) spi_bit(1'($urandom_range(0, 1)), d);
    endtask

    task automatic sdi_open();
        XDCS = 1'b0;
        cyc(HALF);
    endtask

    task automatic sdi_close();
        cyc(HALF);
        XDCS = 1'b1;
        cyc(6);
    endtask

    task automatic drain(input string name);
        byte_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH && byte_valid; i++) cyc(1);
        byte_ready = 1'b0;
        cyc(1);
        chk({name, "_left"}, 32'(exp_q.size()), 0);
        chk({name, "_valid"}, 32'(byte_valid), 0);
    endtask

    task automatic wait_dreq(input string name, input int limit, output int n);
        n = 0;
        while (!DREQ && n < limit) begin
            cyc(1);
            n++;
        end
        chk({name, "_dreq"}, 32'(DREQ), 1);
    endtask

    task automatic check_reset(input string name);
        chk({name, "_dreq"}, 32'(DREQ), 0);
        chk({name, "_so"}, 32'(SO), 0);
        chk({name, "_mode"}, 32'(mode), 0);
        chk({name, "_vol"}, 32'(vol), 0);
        chk({name, "_valid"}, 32'(byte_valid), 0);
        chk({name, "_ovf"}, 32'(ovf), 0);
        chk({name, "_err"}, 32'(frm_err), 0);
    endtask

    initial begin
        logic [15:0] rd;
        logic        dm;
        int          n;
        logic [7:0]  first_b, b;
        logic [31:0] r;
        logic [3:0]  a;
        logic [15:0] d;

        model_clear();
        m_ovf = 1'b0;
        cyc(3);
        check_reset("por");
        RST = 1'b1;
        wait_dreq("boot", 3 * BOOT, n);
        chk("boot_len", 32'(n >= BOOT && n <= BOOT + 8), 1);

        sci_frame(32'h020B1234, 32, rd, dm);
        model_write(4'hB, 16'h1234);
        chk("wr_dreq_mid", 32'(dm), 0);
        chk("wr_vol", 32'(vol), 32'(mregs[11]));
        chk("wr_err", 32'(frm_err), 0);
        chk("wr_dreq_after", 32'(DREQ), 1);

        sci_frame(32'h030B0000, 32, rd, dm);
        chk("rd_so", 32'(rd), 32'(mregs[11]));
        chk("rd_vol", 32'(vol), 32'(mregs[11]));

        sdi_open();
        sdi_byte(8'hA5);
        sdi_byte(8'h5A);
        sdi_close();
        drain("sdi_word");

        sdi_open();
        sdi_byte(8'h3C);
        sdi_bits(4);
        sdi_close();
        chk("partial_count", 32'(byte_valid), 1);
        drain("sdi_partial");

        sdi_open();
        for (int i = 0; i < 3; i++) sdi_byte(8'($urandom));
        sdi_close();
        sci_frame(32'h02000804, 32, rd, dm);
        model_write(4'h0, 16'h0804);
        chk("soft_mode", 32'(mode), 32'(mregs[0]));
        chk("soft_fifo", 32'(byte_valid), 32'(exp_q.size() != 0));
        chk("soft_vol", 32'(vol), 32'(mregs[11]));
        wait_dreq("soft", 3 * BOOT, n);
        chk("soft_len", 32'(n + 6 >= BOOT && n + 6 <= BOOT + 8), 1);

        sdi_open();
        for (int k = 1; k <= 65; k++) begin
            b = 8'($urandom);
            if (k == 1) first_b = b;
            sdi_byte(b);
            if (k == 32 || k == 33) begin
                cyc(3);
                chk($sformatf("dreq_after_%0d", k), 32'(DREQ),
                    32'((DEPTH - exp_q.size()) >= MARGIN));
            end
        end
        cyc(3);
        chk("full_ovf", 32'(ovf), 32'(m_ovf));
        chk("full_head", 32'(byte_data), 32'(first_b));
        sdi_close();
        drain("full");

        sci_frame(32'h020BABCD, 20, rd, dm);
        chk("abort_err", 32'(frm_err), 1);
        chk("abort_vol", 32'(vol), 32'(mregs[11]));

        XRESET = 1'b0;
        cyc(6);
        model_clear();
        chk("xrst_vol", 32'(vol), 0);
        chk("xrst_mode", 32'(mode), 0);
        chk("xrst_err_held", 32'(frm_err), 1);
        chk("xrst_ovf_held", 32'(ovf), 1);
        chk("xrst_dreq", 32'(DREQ), 0);
        XRESET = 1'b1;
        wait_dreq("xrst", 3 * BOOT, n);

        sdi_open();
        sdi_byte(8'h77);
        sdi_bits(4);
        RST = 1'b0;
        XDCS = 1'b1;
        cyc(2);
        model_clear();
        m_ovf = 1'b0;
        check_reset("rst_mid");
        RST = 1'b1;
        wait_dreq("rst_mid", 3 * BOOT, n);

        sci_frame(32'h020B00AA, 32, rd, dm);
        model_write(4'hB, 16'h00AA);
        sdi_open();
        sdi_byte(8'hC3);
        sdi_close();
        XCS = 1'b0;
        XDCS = 1'b0;
        cyc(8);
        XCS = 1'b1;
        XDCS = 1'b1;
        cyc(6);
        chk("both_err", 32'(frm_err), 1);
        chk("both_vol", 32'(vol), 32'(mregs[11]));
        drain("both");

        RST = 1'b0;
        cyc(2);
        model_clear();
        RST = 1'b1;
        wait_dreq("rst2", 3 * BOOT, n);
        sci_frame(32'h050B5555, 32, rd, dm);
        chk("badop_err", 32'(frm_err), 1);
        chk("badop_vol", 32'(vol), 32'(mregs[11]));

        for (int it = 0; it < 30; it++) begin
            r = $urandom;
            a = r[3:0];
            d = 16'($urandom);
            case ($urandom_range(0, 2))
                0: begin
                    if (a == 4'h0) d[2] = 1'b0;
                    sci_frame({8'h02, r[7:4], a, d}, 32, rd, dm);
                    model_write(a, d);
                end
                1: begin
                    sci_frame({8'h03, r[7:4], a, 16'h0}, 32, rd, dm);
                    chk($sformatf("rnd_rd_%0d", it), 32'(rd), 32'(mregs[a]));
                end
                default: begin
                    sdi_open();
                    for (int j = 0; j < int'($urandom_range(1, 5)); j++) sdi_byte(8'($urandom));
                    sdi_bits($urandom_range(0, 7));
                    sdi_close();
                    drain($sformatf("rnd_sdi_%0d", it));
                end
            endcase
            chk($sformatf("rnd_mode_%0d", it), 32'(mode), 32'(mregs[0]));
            chk($sformatf("rnd_vol_%0d", it), 32'(vol), 32'(mregs[11]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
